// File: rtl/fifo_rd_stream_adapter.sv
// Adapts a pop/empty FIFO (data valid one cycle after pop) to a valid/ready stream via a 3-entry skid buffer.
// Optional m_last generation is compiled in with `define FIFO_RD_ADAPTER_LAST_EN.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   // Stream handshake: a beat moves when m_valid && m_ready on a rising edge;
   // m_valid/m_data never depend on m_ready and hold steady until the beat moves.

   logic [1:0]            occ;
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] buf_mem [3];
   logic [2:0]            credit_used;
   logic                  capture;
   logic                  xfer;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Credits count both stored beats and the one still on its way from the FIFO,
   // so a capture can never land in a full buffer.
   assign credit_used = {1'b0, occ} + {2'b00, inflight};
   assign fifo_pop    = reset && !fifo_empty && (credit_used < 3'd3);
   assign capture     = inflight;
   assign m_valid     = (occ != 2'd0);
   assign xfer        = m_valid && m_ready;

   always_comb begin
      m_data = buf_mem[2];
      case (rd_ptr)
         2'd0:    m_data = buf_mem[0];
         2'd1:    m_data = buf_mem[1];
         default: m_data = buf_mem[2];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
      end else begin
         inflight <= fifo_pop;
         if (capture) wr_ptr <= next_ptr(wr_ptr);
         if (xfer)    rd_ptr <= next_ptr(rd_ptr);
         case ({capture, xfer})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage is cleared on reset so m_data reads zero until the first capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (capture && (wr_ptr == 2'(i))) buf_mem[i] <= fifo_data;
         end
      end
   end

`ifdef FIFO_RD_ADAPTER_LAST_EN
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

   logic [CNT_WIDTH-1:0] beat_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt <= '0;
      end else if (xfer) begin
         beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + 1'b1;
      end
   end

   assign m_last = m_valid && (beat_cnt == LAST_CNT);
`else
   assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: behavioural upstream FIFO, expected-data queue, linear test steps.
// Build with +define+FIFO_RD_ADAPTER_LAST_EN to check m_last on a 4-beat burst length.
module tb_fifo_rd_stream_adapter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         fifo_empty;
   logic [W-1:0] fifo_data = '0;
   logic         fifo_pop;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic         m_last;

   fifo_rd_stream_adapter #(
      .DATA_WIDTH(W),
      .BURST_LEN (4),
      .CNT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .fifo_pop  (fifo_pop),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   always #5 clk = ~clk;

   // Upstream FIFO model: data appears on fifo_data the cycle after a pop.
   logic [W-1:0] up_mem [2048];
   int           up_wr = 0;
   int           up_rd = 0;
   logic         gap = 1'b0;

   assign fifo_empty = (up_wr == up_rd) || gap;

   always @(posedge clk) begin
      if (fifo_pop) begin
         fifo_data <= up_mem[up_rd];
         up_rd     <= up_rd + 1;
      end
   end

   // Scoreboard and statistics
   logic [W-1:0] exp_q[$];
   int passed = 0;
   int total  = 0;
   int tb_beat = 0;
   int cyc, pops, beats, lasts, overflow;
   int first_pop, last_pop, first_beat, last_beat, first_valid;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic push(input logic [W-1:0] v);
      up_mem[up_wr] = v;
      up_wr = up_wr + 1;
      exp_q.push_back(v);
   endtask

   task automatic flush_upstream();
      up_wr = up_rd;
      exp_q.delete();
   endtask

   task automatic clear_win();
      cyc = 0; pops = 0; beats = 0; lasts = 0;
      first_pop = -1; last_pop = -1; first_beat = -1; last_beat = -1; first_valid = -1;
   endtask

   // Called just after a falling edge with inputs already set; samples mid-cycle,
   // scores any beat that the next rising edge will transfer, then waits one cycle.
   task automatic step();
      logic [W-1:0] e;
      logic         exp_last;
      #1;
      if (dut.inflight && (dut.occ == 2'd3)) overflow++;
      if (fifo_pop) begin
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
         beats++;
         if (first_beat < 0) first_beat = cyc;
         last_beat = cyc;
`ifdef FIFO_RD_ADAPTER_LAST_EN
         exp_last = ((tb_beat % 4) == 3);
`else
         exp_last = 1'b0;
`endif
         if (m_last) lasts++;
         check("m_last_per_beat", W'(m_last), W'(exp_last));
         tb_beat++;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", m_data, 'x);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b0;
      m_ready = 1'b0;
      overflow = 0;
      clear_win();
      @(negedge clk);

      // Reset holds the pop low even with data available upstream
      push(64'hDEAD);
      repeat (2) @(negedge clk);
      #1;
      check("rst_fifo_pop", W'(fifo_pop), W'(0));
      check("rst_m_valid", W'(m_valid), W'(0));
      check("rst_m_data", m_data, '0);
      check("rst_m_last", W'(m_last), W'(0));
      flush_upstream();
      @(negedge clk);

      // Streaming 0x1..0x20 with m_ready high
      for (int i = 1; i <= 32; i++) push(W'(i));
      m_ready = 1'b1;
      reset   = 1'b1;
      clear_win();
      repeat (40) step();
      check("stream_first_valid", W'(first_valid), W'(2));
      check("stream_pops", W'(pops), W'(32));
      check("stream_pop_span", W'(last_pop - first_pop + 1), W'(32));
      check("stream_beats", W'(beats), W'(32));
      check("stream_beat_span", W'(last_beat - first_beat + 1), W'(32));
      check("stream_drained", W'(exp_q.size()), W'(0));

      // Asynchronous reset in the middle of a cycle
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(W'(64'h100 + i));
      clear_win();
      repeat (4) step();
      #1;
      check("pre_async_valid", W'(m_valid), W'(1));
      #1;
      reset = 1'b0;
      tb_beat = 0;
      #1;
      check("async_m_valid", W'(m_valid), W'(0));
      check("async_m_data", m_data, '0);
      check("async_fifo_pop", W'(fifo_pop), W'(0));
      @(negedge clk);
      flush_upstream();
      @(negedge clk);

      // Backpressure with ten entries upstream
      for (int i = 1; i <= 10; i++) push(W'(i));
      reset = 1'b1;
      clear_win();
      repeat (8) step();
      #1;
      check("bp_pops", W'(pops), W'(3));
      check("bp_m_valid", W'(m_valid), W'(1));
      check("bp_m_data_hold", m_data, W'(1));
      check("bp_fifo_pop_low", W'(fifo_pop), W'(0));
      @(negedge clk);
      m_ready = 1'b1;
      clear_win();
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
      check("bp_beats", W'(beats), W'(10));
      check("bp_drained", W'(exp_q.size()), W'(0));

      // Single entry
      push(W'(8'hAB));
      clear_win();
      repeat (6) step();
      #1;
      check("single_pops", W'(pops), W'(1));
      check("single_beats", W'(beats), W'(1));
      check("single_m_valid", W'(m_valid), W'(0));
      check("single_fifo_pop", W'(fifo_pop), W'(0));
      @(negedge clk);

      // Random backpressure and upstream gaps
      for (int i = 0; i < 1000; i++) push({$urandom, $urandom});
      clear_win();
      overflow = 0;
      for (int k = 0; k < 10000 && exp_q.size() != 0; k++) begin
         m_ready = 1'($urandom_range(0, 1));
         gap     = ($urandom_range(0, 3) == 0);
         step();
      end
      gap = 1'b0;
      m_ready = 1'b1;
      check("rand_beats", W'(beats), W'(1000));
      check("rand_drained", W'(exp_q.size()), W'(0));
      check("rand_no_full_capture", W'(overflow), W'(0));

      // Burst marking over 12 beats after a fresh reset
      reset = 1'b0;
      tb_beat = 0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) push(W'(64'h200 + i));
      clear_win();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
      check("burst_beats", W'(beats), W'(12));
`ifdef FIFO_RD_ADAPTER_LAST_EN
      check("burst_last_count", W'(lasts), W'(3));
`else
      check("burst_last_count", W'(lasts), W'(0));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
